// File: rtl/multi_edge_detector_if.sv
// Bundle of the per-channel input strobes and edge-event outputs of multi_edge_detector.
// master drives the raw inputs and enables; slave is the detector itself.
interface multi_edge_detector_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] in_sig;
  logic [CHANNELS-1:0] rise_en;
  logic [CHANNELS-1:0] fall_en;
  logic [CHANNELS-1:0] flag_clr;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] event_flag;
  logic                irq;

  modport master (
    output in_sig, rise_en, fall_en, flag_clr,
    input  rise_pulse, fall_pulse, level, event_flag, irq
  );

  modport slave (
    input  in_sig, rise_en, fall_en, flag_clr,
    output rise_pulse, fall_pulse, level, event_flag, irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser, persistence filter, rise/fall pulse
// stretchers and sticky event flags with an interrupt summary.
module multi_edge_detector #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int PULSE_WIDTH   = 1
) (
  input logic                  clk,
  input logic                  rst,
  multi_edge_detector_if.slave bus
);
  localparam int               FILT_EFF = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int               CNT_W    = $clog2(FILT_EFF + 1);
  localparam logic [7:0]       PW_LOAD  = 8'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_EFF - 1);

  // Retrigger reloads the full width; otherwise count down and hold at zero.
  function automatic logic [7:0] stretch_next(input logic ev, input logic [7:0] cur);
    if (ev)
      return PW_LOAD;
    else if (cur != 8'd0)
      return cur - 8'd1;
    else
      return 8'd0;
  endfunction

  // ---- stage p0: synchroniser ----
  logic [CHANNELS-1:0] sync_in_p0;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [CHANNELS-1:0] chain_p0 [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) chain_p0[k] <= '0;
        end else begin
          chain_p0[0] <= bus.in_sig;
          for (int k = 1; k < SYNC_STAGES; k++) chain_p0[k] <= chain_p0[k-1];
        end
      end

      assign sync_in_p0 = chain_p0[SYNC_STAGES-1];
    end else begin : g_nosync
      assign sync_in_p0 = bus.in_sig;
    end
  endgenerate

  // ---- stage p1: persistence filter and edge classification ----
  logic [CHANNELS-1:0] level_p1;
  logic [CNT_W-1:0]    cnt_p1 [CHANNELS];
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] rise_ev;
  logic [CHANNELS-1:0] fall_ev;

  always_comb begin
    accept = '0;
    for (int c = 0; c < CHANNELS; c++)
      accept[c] = (sync_in_p0[c] != level_p1[c]) && (cnt_p1[c] == CNT_LAST);
  end

  assign rise_ev = accept & ~level_p1 & bus.rise_en;
  assign fall_ev = accept &  level_p1 & bus.fall_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_p1 <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt_p1[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync_in_p0[c] == level_p1[c]) begin
          cnt_p1[c] <= '0;
        end else if (accept[c]) begin
          level_p1[c] <= sync_in_p0[c];
          cnt_p1[c]   <= '0;
        end else begin
          cnt_p1[c] <= cnt_p1[c] + 1'b1;
        end
      end
    end
  end

  // ---- stage p2: pulse stretchers, sticky flags, irq ----
  logic [7:0]          rise_cnt_p2 [CHANNELS];
  logic [7:0]          fall_cnt_p2 [CHANNELS];
  logic [7:0]          rise_nxt    [CHANNELS];
  logic [7:0]          fall_nxt    [CHANNELS];
  logic [CHANNELS-1:0] rise_q_p2;
  logic [CHANNELS-1:0] fall_q_p2;
  logic [CHANNELS-1:0] flag_p2;
  logic [CHANNELS-1:0] flag_nxt;
  logic                irq_p2;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rise_nxt[c] = stretch_next(rise_ev[c], rise_cnt_p2[c]);
      fall_nxt[c] = stretch_next(fall_ev[c], fall_cnt_p2[c]);
    end
  end

  // A new edge outranks a simultaneous clear.
  assign flag_nxt = (flag_p2 & ~bus.flag_clr) | rise_ev | fall_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rise_cnt_p2[c] <= 8'd0;
        fall_cnt_p2[c] <= 8'd0;
      end
      rise_q_p2 <= '0;
      fall_q_p2 <= '0;
      flag_p2   <= '0;
      irq_p2    <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        rise_cnt_p2[c] <= rise_nxt[c];
        fall_cnt_p2[c] <= fall_nxt[c];
        rise_q_p2[c]   <= (rise_nxt[c] != 8'd0);
        fall_q_p2[c]   <= (fall_nxt[c] != 8'd0);
      end
      flag_p2 <= flag_nxt;
      irq_p2  <= |flag_nxt;
    end
  end

  assign bus.rise_pulse = rise_q_p2;
  assign bus.fall_pulse = fall_q_p2;
  assign bus.level      = level_p1;
  assign bus.event_flag = flag_p2;
  assign bus.irq        = irq_p2;

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel edge detector: successor to the single-channel rise/fall pulse block. Each channel gets an optional N-stage synchroniser, a glitch filter that requires a new level to persist before it is accepted, per-channel rise/fall enables, programmable output pulse width, and a sticky event flag with an interrupt summary. It sits between asynchronous external inputs (buttons, strobes, status lines) and the control logic that consumes edge events.

## Interface
- CHANNELS, 4: number of independent input channels (1..32).
- SYNC_STAGES, 2: synchroniser depth; 0 bypasses the synchroniser, so in_sig must then be synchronous to clk.
- FILTER_CYCLES, 0: consecutive cycles a changed level must persist before it is accepted; 0 and 1 both mean no filtering.
- PULSE_WIDTH, 1: output pulse length in clk cycles (1..255).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_sig  in  CHANNELS  raw input levels.
- rise_en  in  CHANNELS  per-channel enable for rising-edge reporting.
- fall_en  in  CHANNELS  per-channel enable for falling-edge reporting.
- flag_clr  in  CHANNELS  per-channel clear of event_flag; single-cycle strobe.
- rise_pulse  out  CHANNELS  registered rising-edge pulse, PULSE_WIDTH cycles long.
- fall_pulse  out  CHANNELS  registered falling-edge pulse, PULSE_WIDTH cycles long.
- level  out  CHANNELS  accepted (filtered) level per channel.
- event_flag  out  CHANNELS  sticky flag: an enabled edge has occurred.
- irq  out  1  registered OR of event_flag.

## Operation
- **Synchroniser:** a per-channel shift chain, SYNC_STAGES deep. sync_in is the last stage, or in_sig directly when SYNC_STAGES=0.
- **Filter:** per-channel registers level and cnt, with cnt width clog2(max(FILTER_CYCLES,1)+1). Each cycle:
  - if sync_in == level, cnt <= 0.
  - else if cnt == max(FILTER_CYCLES,1)-1, level <= sync_in and cnt <= 0. This is the "accept" event.
  - else cnt <= cnt+1.
  - Consequence: a glitch shorter than FILTER_CYCLES cycles never changes level, and the counter restarts from 0 after each interruption.
- **Edge event:** an accept from 0 to 1 is a rise; an accept from 1 to 0 is a fall. Each is gated by rise_en or fall_en, sampled in the accept cycle.
- **Pulse stretcher:** separate rise and fall down-counters per channel, 8 bits each.
  - An enabled event loads PULSE_WIDTH.
  - Otherwise a nonzero counter decrements.
  - rise_pulse = (rise counter != 0); fall_pulse likewise. Each output is driven by a register bit set on the same edge as the load, so both outputs are glitch-free.
  - Retrigger: a new same-type event during a pulse reloads PULSE_WIDTH, extending the pulse.
  - Rise and fall pulses of one channel may overlap when PULSE_WIDTH > max(FILTER_CYCLES,1). This is legal.
  - Deasserting an enable does not truncate a pulse already in progress.
- **Sticky flag:**
  - event_flag[i] is set on any enabled edge of channel i and cleared by flag_clr[i].
  - If set and clear occur in the same cycle, set wins.
  - irq <= |event_flag_next, so irq rises on the same edge as the flag.
- **Reset:** all registers, including level, go to 0. An input held high through reset therefore produces a rise event after the normal latency once rst is released.

## Timing
- Reset values: rise_pulse, fall_pulse, level, event_flag and irq are all 0, as are every internal synchroniser, filter and stretcher register.
- rst is sampled on the clk edge. Asserting it mid-pulse or mid-filter forces all outputs to 0 on that edge with no partial completion.
- Latency: let E1 be the first edge that samples a new in_sig level, with in_sig then held. level, rise_pulse/fall_pulse and event_flag change on edge E(SYNC_STAGES + max(FILTER_CYCLES,1)).
  - Default parameters (SYNC_STAGES=2, FILTER_CYCLES=0): the change happens on E3.
- Pulses are high for exactly PULSE_WIDTH cycles unless retriggered or reset.
- Minimum spacing for back-to-back accepted edges on one channel: max(FILTER_CYCLES,1) cycles.
- Channels are fully independent. Simultaneous events on all channels are all reported.

## Test plan
- Defaults, CHANNELS=4: ch0 goes 0→1 at E1 and is held → rise_pulse[0]=1 for exactly one cycle after E3, level[0]=1 and event_flag[0]=1 from E3, irq=1 from E3. Other channels stay 0.
- FILTER_CYCLES=4, SYNC_STAGES=2: a 3-cycle high glitch on ch1 → no pulse and level[1] stays 0. A 4-cycle high → rise pulse after E6 and level[1]=1.
- PULSE_WIDTH=5: rise on ch2 → rise_pulse[2] high for 5 cycles. A second rise accepted 3 cycles later reloads the counter → 8 contiguous high cycles total.
- rise_en=0, fall_en=1 on ch3: a 0→1→0 input → no rise_pulse, one fall_pulse, level[3] follows both transitions, event_flag[3] set only by the fall.
- flag_clr[0] asserted in the same cycle as a new enabled edge on ch0 → event_flag[0] stays 1. flag_clr[0] alone → flag 0 next edge and irq 0 if no other flags are set.
- in_sig[0]=1 held through reset, rst asserted mid-pulse (PULSE_WIDTH=5): all outputs 0 on the rst edge. After release, a rise pulse follows after E3 latency.
